cellift_mem_port_arbiter: RTL and testbench

CELLIFT_MEM_PORT_ARBITER -- requirements
Module: cellift_mem_port_arbiter

---
 rtl/cellift_mem_arb_pkg.sv | 14 +
 rtl/cellift_mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cellift_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cellift_mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package cellift_mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } requester_e;

endpackage

// File: rtl/cellift_mem_port_arbiter.sv
// Two-requester (instruction/data) arbiter onto one single-ported memory,
// round-robin on contest, selection held stable while the memory stalls.
module cellift_mem_port_arbiter
    import cellift_mem_arb_pkg::*;
#(
    parameter int AddrW = 21,
    parameter int DataW = 32,
    parameter int StrbW = 32,
    parameter int CntW  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             instr_req_i,
    output logic             instr_gnt_o,
    input  logic [AddrW-1:0] instr_addr_i,
    input  logic [DataW-1:0] instr_wdata_i,
    input  logic [StrbW-1:0] instr_strb_i,
    input  logic             instr_we_i,
    output logic [DataW-1:0] instr_rdata_o,
    output logic             instr_rvalid_o,

    input  logic             data_req_i,
    output logic             data_gnt_o,
    input  logic [AddrW-1:0] data_addr_i,
    input  logic [DataW-1:0] data_wdata_i,
    input  logic [StrbW-1:0] data_strb_i,
    input  logic             data_we_i,
    output logic [DataW-1:0] data_rdata_o,
    output logic             data_rvalid_o,

    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    output logic [StrbW-1:0] mem_strb_o,
    output logic             mem_we_o,
    input  logic [DataW-1:0] mem_rdata_i,

    output logic [CntW-1:0]  conflict_cnt_o,
    output logic [CntW-1:0]  stall_cnt_o
);

    arb_state_e  state_q, state_d;
    requester_e  last_q, last_d;
    requester_e  hold_q, hold_d;
    logic        pend_q, pend_d;
    requester_e  owner_q, owner_d;
    logic [CntW-1:0] conflict_cnt_q, conflict_cnt_d;
    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;

    requester_e  sel;
    requester_e  rr_sel;
    logic        any_req;
    logic        both_req;
    logic        hold_req;
    logic        hold_valid;
    logic        grant;
    logic        stall;

    assign any_req  = instr_req_i | data_req_i;
    assign both_req = instr_req_i & data_req_i;
    assign hold_req = (hold_q == INSTR) ? instr_req_i : data_req_i;

    // A held selection whose requester has withdrawn is abandoned in the same
    // cycle, so the fresh arbitration below takes over with no bubble.
    assign hold_valid = (state_q == ARB_HOLD) && hold_req;

    always_comb begin
        rr_sel = INSTR;
        if (both_req) begin
            rr_sel = (last_q == INSTR) ? DATA : INSTR;
        end else if (data_req_i) begin
            rr_sel = DATA;
        end
    end

    assign sel   = hold_valid ? hold_q : rr_sel;
    assign grant = mem_gnt_i & any_req;
    assign stall = any_req & ~mem_gnt_i;

    assign instr_gnt_o = mem_gnt_i & instr_req_i & (sel == INSTR);
    assign data_gnt_o  = mem_gnt_i & data_req_i  & (sel == DATA);

    always_comb begin
        mem_req_o   = any_req;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        mem_we_o    = 1'b0;
        if (any_req) begin
            if (sel == INSTR) begin
                mem_addr_o  = instr_addr_i;
                mem_wdata_o = instr_wdata_i;
                mem_strb_o  = instr_strb_i;
                mem_we_o    = instr_we_i;
            end else begin
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
                mem_strb_o  = data_strb_i;
                mem_we_o    = data_we_i;
            end
        end
    end

    always_comb begin
        state_d        = ARB_IDLE;
        hold_d         = hold_q;
        last_d         = last_q;
        pend_d         = 1'b0;
        owner_d        = owner_q;
        conflict_cnt_d = conflict_cnt_q;
        stall_cnt_d    = stall_cnt_q;

        if (stall) begin
            state_d = ARB_HOLD;
            hold_d  = sel;
        end

        if (grant) begin
            last_d = sel;
            // Writes get no response; only reads arm the return path.
            if (!mem_we_o) begin
                pend_d  = 1'b1;
                owner_d = sel;
            end
        end

        if (both_req && (conflict_cnt_q != {CntW{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
        if (stall && (stall_cnt_q != {CntW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ARB_IDLE;
            last_q         <= DATA;
            hold_q         <= INSTR;
            pend_q         <= 1'b0;
            owner_q        <= INSTR;
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            hold_q         <= hold_d;
            pend_q         <= pend_d;
            owner_q        <= owner_d;
            conflict_cnt_q <= conflict_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign instr_rvalid_o = pend_q & (owner_q == INSTR);
    assign data_rvalid_o  = pend_q & (owner_q == DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

    assign conflict_cnt_o = conflict_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_cellift_mem_port_arbiter.sv
// Directed bench for the memory port arbiter; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_cellift_mem_port_arbiter;

    localparam int AddrW = 21;
    localparam int DataW = 32;
    localparam int StrbW = 32;
    localparam int CntW  = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             instr_req_i, instr_we_i, data_req_i, data_we_i, mem_gnt_i;
    logic [AddrW-1:0] instr_addr_i, data_addr_i;
    logic [DataW-1:0] instr_wdata_i, data_wdata_i, mem_rdata_i;
    logic [StrbW-1:0] instr_strb_i, data_strb_i;

    logic             instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic [DataW-1:0] instr_rdata_o, data_rdata_o, mem_wdata_o;
    logic             mem_req_o, mem_we_o;
    logic [AddrW-1:0] mem_addr_o;
    logic [StrbW-1:0] mem_strb_o;
    logic [CntW-1:0]  conflict_cnt_o, stall_cnt_o;

    logic             s_instr_gnt, s_instr_rvalid, s_data_gnt, s_data_rvalid;
    logic [DataW-1:0] s_instr_rdata, s_data_rdata, s_mem_wdata;
    logic             s_mem_req, s_mem_we;
    logic [AddrW-1:0] s_mem_addr;
    logic [StrbW-1:0] s_mem_strb;
    logic [3:0]       s_conflict_cnt, s_stall_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    cellift_mem_port_arbiter #(.AddrW(AddrW), .DataW(DataW), .StrbW(StrbW), .CntW(CntW)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
        .instr_wdata_i(instr_wdata_i), .instr_strb_i(instr_strb_i), .instr_we_i(instr_we_i),
        .instr_rdata_o(instr_rdata_o), .instr_rvalid_o(instr_rvalid_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_strb_i(data_strb_i), .data_we_i(data_we_i),
        .data_rdata_o(data_rdata_o), .data_rvalid_o(data_rvalid_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_we_o(mem_we_o),
        .mem_rdata_i(mem_rdata_i),
        .conflict_cnt_o(conflict_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    cellift_mem_port_arbiter #(.AddrW(AddrW), .DataW(DataW), .StrbW(StrbW), .CntW(4)) u_dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_gnt_o(s_instr_gnt), .instr_addr_i(instr_addr_i),
        .instr_wdata_i(instr_wdata_i), .instr_strb_i(instr_strb_i), .instr_we_i(instr_we_i),
        .instr_rdata_o(s_instr_rdata), .instr_rvalid_o(s_instr_rvalid),
        .data_req_i(data_req_i), .data_gnt_o(s_data_gnt), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_strb_i(data_strb_i), .data_we_i(data_we_i),
        .data_rdata_o(s_data_rdata), .data_rvalid_o(s_data_rvalid),
        .mem_req_o(s_mem_req), .mem_gnt_i(mem_gnt_i), .mem_addr_o(s_mem_addr),
        .mem_wdata_o(s_mem_wdata), .mem_strb_o(s_mem_strb), .mem_we_o(s_mem_we),
        .mem_rdata_i(mem_rdata_i),
        .conflict_cnt_o(s_conflict_cnt), .stall_cnt_o(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_i = 1'b0; instr_we_i = 1'b0; instr_addr_i = '0;
        instr_wdata_i = '0; instr_strb_i = '0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0;
        data_wdata_i = '0; data_strb_i = '0;
        mem_gnt_i = 1'b0; mem_rdata_i = '0;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;

        // Reset values, and combinational path alive while in reset
        instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        #2;
        chk("rst_instr_rvalid", 64'(instr_rvalid_o), 64'd0);
        chk("rst_data_rvalid", 64'(data_rvalid_o), 64'd0);
        chk("rst_conflict", 64'(conflict_cnt_o), 64'd0);
        chk("rst_stall", 64'(stall_cnt_o), 64'd0);
        chk("rst_mem_req", 64'(mem_req_o), 64'd1);
        chk("rst_instr_gnt", 64'(instr_gnt_o), 64'd1);
        cyc();
        idle_inputs();
        cyc();
        rst_ni = 1'b1;

        // Lone instr read, granted same cycle, response next cycle
        cyc();
        instr_req_i = 1'b1; instr_addr_i = 21'h00010; mem_gnt_i = 1'b1;
        #1;
        chk("t1_instr_gnt", 64'(instr_gnt_o), 64'd1);
        chk("t1_data_gnt", 64'(data_gnt_o), 64'd0);
        chk("t1_mem_addr", 64'(mem_addr_o), 64'h10);
        cyc();
        idle_inputs(); mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("t1_instr_rvalid", 64'(instr_rvalid_o), 64'd1);
        chk("t1_instr_rdata", 64'(instr_rdata_o), 64'hDEADBEEF);
        chk("t1_data_rvalid", 64'(data_rvalid_o), 64'd0);
        chk("t1_data_rdata", 64'(data_rdata_o), 64'd0);
        cyc();
        chk("t1_rvalid_once", 64'(instr_rvalid_o), 64'd0);

        // Granted data write yields no response
        data_req_i = 1'b1; data_we_i = 1'b1; data_strb_i = 32'hF;
        data_addr_i = 21'h00080; data_wdata_i = 32'h12345678; mem_gnt_i = 1'b1;
        #1;
        chk("t4_data_gnt", 64'(data_gnt_o), 64'd1);
        chk("t4_mem_we", 64'(mem_we_o), 64'd1);
        chk("t4_mem_strb", 64'(mem_strb_o), 64'hF);
        chk("t4_mem_wdata", 64'(mem_wdata_o), 64'h12345678);
        cyc();
        idle_inputs();
        #1;
        chk("t4_instr_rvalid", 64'(instr_rvalid_o), 64'd0);
        chk("t4_data_rvalid", 64'(data_rvalid_o), 64'd0);

        // Contested reads: last winner was DATA, so INSTR,DATA,INSTR,DATA
        cyc();
        for (int k = 0; k < 4; k++) begin
            instr_req_i = 1'b1; instr_addr_i = 21'h00020;
            data_req_i  = 1'b1; data_addr_i  = 21'h00030;
            mem_gnt_i = 1'b1; mem_rdata_i = 32'h100 + 32'(k);
            #1;
            chk("t2_instr_gnt", 64'(instr_gnt_o), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("t2_data_gnt", 64'(data_gnt_o), (k % 2 == 1) ? 64'd1 : 64'd0);
            chk("t2_mem_addr", 64'(mem_addr_o), (k % 2 == 0) ? 64'h20 : 64'h30);
            if (k > 0) begin
                chk("t2_instr_rvalid", 64'(instr_rvalid_o), (k % 2 == 1) ? 64'd1 : 64'd0);
                chk("t2_data_rvalid", 64'(data_rvalid_o), (k % 2 == 0) ? 64'd1 : 64'd0);
                chk("t2_rdata", 64'(instr_rdata_o | data_rdata_o), 64'h100 + 64'(k));
            end
            cyc();
        end
        idle_inputs(); mem_rdata_i = 32'h104;
        #1;
        chk("t2_last_data_rvalid", 64'(data_rvalid_o), 64'd1);
        chk("t2_last_instr_rvalid", 64'(instr_rvalid_o), 64'd0);
        chk("t2_last_rdata", 64'(data_rdata_o), 64'h104);
        chk("t2_conflict", 64'(conflict_cnt_o), 64'd4);
        chk("t2_stall", 64'(stall_cnt_o), 64'd0);

        // Stalled data write keeps the port; instr joins in cycle 2
        cyc();
        for (int k = 1; k <= 5; k++) begin
            data_req_i = (k <= 4); data_we_i = 1'b1; data_addr_i = 21'h00040; data_strb_i = 32'hF;
            instr_req_i = (k >= 2); instr_we_i = 1'b0; instr_addr_i = 21'h00050;
            mem_gnt_i = (k >= 4);
            #1;
            if (k <= 4) begin
                chk("t3_mem_addr", 64'(mem_addr_o), 64'h40);
                chk("t3_mem_we", 64'(mem_we_o), 64'd1);
                chk("t3_data_gnt", 64'(data_gnt_o), (k == 4) ? 64'd1 : 64'd0);
                chk("t3_instr_gnt", 64'(instr_gnt_o), 64'd0);
            end else begin
                chk("t3_c5_instr_gnt", 64'(instr_gnt_o), 64'd1);
                chk("t3_c5_mem_addr", 64'(mem_addr_o), 64'h50);
                chk("t3_stall", 64'(stall_cnt_o), 64'd3);
                chk("t3_conflict", 64'(conflict_cnt_o), 64'd7);
            end
            cyc();
        end
        idle_inputs(); mem_rdata_i = 32'hCAFE0001;
        #1;
        chk("t3_instr_rvalid", 64'(instr_rvalid_o), 64'd1);
        chk("t3_instr_rdata", 64'(instr_rdata_o), 64'hCAFE0001);

        // Read granted, then reset pulsed: response discarded
        cyc();
        instr_req_i = 1'b1; instr_addr_i = 21'h00060; mem_gnt_i = 1'b1;
        #1;
        chk("t5_instr_gnt", 64'(instr_gnt_o), 64'd1);
        cyc();
        idle_inputs(); rst_ni = 1'b0; mem_rdata_i = 32'hBAD0BAD0;
        #1;
        chk("t5_rvalid_in_rst", 64'(instr_rvalid_o), 64'd0);
        chk("t5_conflict_rst", 64'(conflict_cnt_o), 64'd0);
        chk("t5_stall_rst", 64'(stall_cnt_o), 64'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        chk("t5_rvalid_after", 64'(instr_rvalid_o), 64'd0);
        chk("t5_data_rvalid_after", 64'(data_rvalid_o), 64'd0);

        // Continuous contest: first goes to INSTR after reset, 4-bit counter saturates
        for (int k = 1; k <= 20; k++) begin
            instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
            #1;
            if (k == 1) chk("t6_first_instr", 64'(instr_gnt_o), 64'd1);
            chk("t6_mutex", 64'(instr_gnt_o & data_gnt_o), 64'd0);
            cyc();
            if (k == 14) chk("t6_sat_14", 64'(s_conflict_cnt), 64'hE);
            if (k == 15) chk("t6_sat_15", 64'(s_conflict_cnt), 64'hF);
        end
        chk("t6_sat_20", 64'(s_conflict_cnt), 64'hF);
        chk("t6_wide_20", 64'(conflict_cnt_o), 64'd20);
        idle_inputs();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
